// File: rtl/des_pkg.sv
// des_pkg: shared DES S-box tables, P-permutation table and FSM state encoding.
// Latency: n/a (constants and pure combinational helper functions).
// Backpressure: n/a.
package des_pkg;

  // FSM state encoding used by des_sbox_unit
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // FIPS 46-3 S-boxes S1..S8. Each entry packs 64 nibbles, row 0 first,
  // column 0 first, so entry (row, col) sits at nibble index row*16+col
  // counted from the MSB end.
  localparam logic [255:0] SBOX_TBL [0:7] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // P-permutation: output bit i (DES numbering, 1 = MSB) takes input bit P_TBL[i-1]
  localparam int unsigned P_TBL [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // six[5] is the first (leftmost) DES bit of the 6-bit group.
  // Row = outer bits, column = inner four bits.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] six);
    logic [255:0] tbl;
    logic [5:0]   idx;
    tbl = SBOX_TBL[box];
    idx = {six[5], six[0], six[4:1]};
    tbl = tbl << {idx, 2'b00};
    return tbl[255:252];
  endfunction

  // Operates in DES numbering so the table reads straight off FIPS 46-3
  function automatic logic [1:32] des_perm(input logic [1:32] x);
    logic [1:32] y;
    y = '0;
    for (int i = 1; i <= 32; i++) begin
      y[i] = x[P_TBL[i-1]];
    end
    return y;
  endfunction

endpackage

// File: rtl/des_sbox_unit_if.sv
// des_sbox_unit_if: input-word / result handshake bundle for des_sbox_unit.
// Latency: n/a (wires only). Ports: in_valid/in_ready/data_in, abort,
// Backpressure: out_valid/out_ready/data_out; master = producer/consumer side, slave = unit.
interface des_sbox_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:48] data_in;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [1:32] data_out;

  modport master (
    output in_valid, data_in, abort, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, abort, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/des_sbox_lut.sv
// des_sbox_lut: one FIPS 46-3 S-box lookup, 6 bits in, 4 bits out, box chosen by box_idx (0 = S1).
// Latency: 0 cycles, purely combinational. Ports: box_idx, sbox_in (bit 5 = first DES bit), sbox_out.
// Backpressure: none.
module des_sbox_lut
  import des_pkg::*;
(
  input  logic [2:0] box_idx,
  input  logic [5:0] sbox_in,
  output logic [3:0] sbox_out
);

  assign sbox_out = sbox_lookup(box_idx, sbox_in);

endmodule

// File: rtl/des_sbox_unit.sv
// des_sbox_unit: DES S-box layer, LANES boxes evaluated per cycle over 8/LANES BUSY cycles.
// Latency: out_valid rises 8/LANES cycles after the accepting edge; abort returns to IDLE next edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Ports: clk, rst_n, bus (slave).
// Optional macro DES_SBOX_PERM_EN applies the FIPS P-permutation to data_out.
module des_sbox_unit
  import des_pkg::*;
#(
  parameter int LANES = 2  // 1, 2, 4 or 8
) (
  input logic            clk,
  input logic            rst_n,
  des_sbox_unit_if.slave bus
);

  localparam int NGROUPS = 8 / LANES;
  localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(NGROUPS - 1);

  logic [1:0]    state;
  logic [GW-1:0] grp;
  logic [47:0]   din_q;   // bit 47 = DES bit 1
  logic [31:0]   result;  // bit 31 = DES bit 1, S1 in the top nibble

  logic [2:0] lane_box [LANES];
  logic [3:0] lane_nib [LANES];

  // Lane l of group g handles box g*LANES+l
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [5:0] six;

    assign lane_box[l] = 3'(32'(grp) * LANES + l);
    assign six         = din_q[47 - 6*lane_box[l] -: 6];

    des_sbox_lut u_lut (
      .box_idx  (lane_box[l]),
      .sbox_in  (six),
      .sbox_out (lane_nib[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      grp    <= '0;
      din_q  <= '0;
      result <= '0;
    end else if (bus.abort) begin
      // Abort beats a same-cycle in_valid and also ends a delivery in DONE
      state  <= ST_IDLE;
      grp    <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            din_q  <= bus.data_in;
            grp    <= '0;
            result <= '0;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          for (int l = 0; l < LANES; l++) begin
            result[31 - 4*lane_box[l] -: 4] <= lane_nib[l];
          end
          grp <= grp + 1'b1;
          if (grp == LAST_GRP) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Gated by rst_n so in_ready reads 0 for the whole reset window
  assign bus.in_ready  = rst_n & (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);

`ifdef DES_SBOX_PERM_EN
  assign bus.data_out = des_perm(result);
`else
  assign bus.data_out = result;
`endif

endmodule

// File: doc/des_sbox_unit.md
DES_SBOX_UNIT -- requirements
Module: des_sbox_unit

Interface
REQ-001 Parameter LANES, default 2, number of S-boxes evaluated per cycle; legal values 1, 2, 4, 8.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  data_in holds a new 48-bit S-box input word.
REQ-005 in_ready  output  1  unit can accept a word this cycle.
REQ-006 data_in  input  [1:48]  expanded, key-mixed half-block; DES bit numbering, bit 1 = MSB.
REQ-007 abort  input  1  synchronous discard of the current operation.
REQ-008 out_valid  output  1  data_out holds a completed result.
REQ-009 out_ready  input  1  downstream accepts data_out this cycle.
REQ-010 data_out  output  [1:32]  substituted (and optionally permuted) result.

Function
REQ-011 The unit SHALL implement FSM states IDLE, BUSY, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE.
REQ-013 A transfer SHALL occur on in_valid && in_ready; the unit SHALL capture data_in, clear the group counter, and go to BUSY.
REQ-014 S-box k (1..8) SHALL take data_in bits 6k-5..6k, with row = {bit 6k-5, bit 6k} and column = bits 6k-4..6k-1, per FIPS 46-3 tables.
REQ-015 The result nibble of S-box k SHALL occupy result bits 4k-3..4k.
REQ-016 In BUSY, each cycle SHALL evaluate S-boxes g*LANES+1 .. (g+1)*LANES, where g is the group counter, and write their nibbles into the result register.
REQ-017 The group counter SHALL be ceil(log2(8/LANES)) bits wide (minimum 1) and SHALL increment by 1 per BUSY cycle.
REQ-018 After group 8/LANES-1 the FSM SHALL go to DONE; out_valid SHALL rise exactly 8/LANES cycles after the accepting edge.
REQ-019 In DONE, out_valid SHALL stay 1 and data_out SHALL remain stable until out_ready is 1.
REQ-020 DONE with out_ready SHALL return to IDLE; in_ready SHALL be 1 on the following cycle; no same-cycle back-to-back accept.
REQ-021 abort in any state SHALL move to IDLE on the next edge, drop out_valid, and discard the result.
REQ-022 abort and in_valid together in IDLE: abort SHALL win; no word is accepted.
REQ-023 abort and out_ready together in DONE: the result SHALL count as delivered.
REQ-024 in_valid during BUSY or DONE SHALL be ignored (no capture, no state change).
REQ-025 data_out SHALL be driven from the result register only; no combinational path from data_in.

Reset
REQ-026 rst_n low SHALL force IDLE, group counter 0, result register 0, out_valid 0, in_ready 0 while rst_n is low.
REQ-027 Reset asserted mid-operation SHALL discard all state.
REQ-028 The first in_ready SHALL occur in the first cycle after rst_n deasserts.

Configuration
REQ-029 Macro DES_SBOX_PERM_EN: when defined, data_out SHALL be the FIPS P-permutation of the 32-bit S-box result, with latency unchanged.
REQ-030 Without DES_SBOX_PERM_EN, data_out SHALL be the raw concatenation of S1..S8.

Structure
REQ-031 Package des_pkg SHALL hold the eight 64x4 S-box tables, the P-permutation table, and the FSM state encoding.
REQ-032 Sub-module des_sbox_lut SHALL be a combinational 6-bit to 4-bit lookup with a box-index input, instantiated LANES times.

Verification
REQ-033 LANES=2, macro undefined, data_in all zeros -> out_valid 4 cycles after accept, data_out = 32'hEFA72C4D.
REQ-034 LANES=1/4/8, data_in all ones -> data_out = 32'hD9CE3DCB, out_valid after 8/2/1 cycles.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> data_out and out_valid stable; in_ready stays 0 throughout.
REQ-036 abort in the 2nd BUSY cycle (LANES=1) -> next cycle IDLE, in_ready=1, out_valid never asserted; a new word then gives the correct result.
REQ-037 rst_n pulsed low mid-BUSY -> outputs are 0 immediately; after release the next transfer gives the correct result.
REQ-038 DES_SBOX_PERM_EN defined, all-zero input -> data_out equals P(32'hEFA72C4D), computed from the package table.
